// File: rtl/pll_mon_pkg.sv
// pll_mon_pkg: shared types for the PLL lock monitor.
// State encoding is visible on the state output port.
package pll_mon_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/ref_edge_sync.sv
// ref_edge_sync: 2-FF synchronizer plus registered rising-edge detect.
// edge_o pulses for one cycle, three clocks after a rising d_i.
module ref_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic edge_q;

    // Synchronize the reference and register a one-cycle edge pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= s2_q & ~s3_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: lock detector and frequency monitor for digital_pll.
// Counts clockp cycles over a window of osc periods and tracks lock.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned TRIM_W      = 26,
    parameter int unsigned DIV_W       = 5,
    parameter int unsigned WIN_REFS    = 8,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned TOL_SHIFT   = 6,
    parameter int unsigned LOCK_WINS   = 3,
    parameter int unsigned UNLOCK_WINS = 2,
    parameter int unsigned TRIM_STABLE = 5,
    parameter int unsigned LT_W        = 16
) (
    input  logic                    clockp,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    osc,
    input  logic [DIV_W-1:0]        div,
    input  logic [TRIM_W-1:0]       trim,
    input  logic                    clear,
    output logic                    locked,
    output logic [STATE_W-1:0]      state,
    output logic [CNT_W-1:0]        meas_count,
    output logic signed [CNT_W:0]   freq_err,
    output logic [LT_W-1:0]         lock_time,
    output logic                    lock_pulse,
    output logic                    unlock_pulse,
    output logic                    loss_flag
);

    localparam int unsigned RW = $clog2(WIN_REFS);
    localparam int unsigned SW = $clog2(TRIM_STABLE + 1);
    localparam int unsigned GW = $clog2(LOCK_WINS + 1);
    localparam int unsigned BW = $clog2(UNLOCK_WINS + 1);

    localparam logic [RW-1:0]    REF_LAST  = RW'(WIN_REFS - 1);
    localparam logic [SW-1:0]    STAB_MAX  = SW'(TRIM_STABLE);
    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_WINS - 1);
    localparam logic [BW-1:0]    BAD_LAST  = BW'(UNLOCK_WINS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [LT_W-1:0]  LT_MAX    = '1;

    // Reference edge, div tracking and trim sampling
    logic               ref_edge;
    logic [DIV_W-1:0]   div_q;
    logic [1:0]         edge_dly_q;
    logic [TRIM_W-1:0]  trim_q;
    logic [TRIM_W-1:0]  trim_d;
    logic [SW-1:0]      stab_q;
    logic [SW-1:0]      stab_d;
    logic               trim_smp;
    logic               trim_stable;
    logic               active;
    logic               div_chg;

    // Window datapath
    logic               synced_q;
    logic               synced_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [RW-1:0]      refc_q;
    logic [RW-1:0]      refc_d;
    logic [CNT_W-1:0]   meas_q;
    logic [CNT_W-1:0]   meas_d;
    logic [CNT_W:0]     ferr_q;
    logic [CNT_W:0]     ferr_d;
    logic               eval_q;
    logic               eval_d;
    logic               sat_q;
    logic               sat_d;
    logic [CNT_W-1:0]   target;
    logic [CNT_W-1:0]   tol;
    logic [CNT_W:0]     ferr_neg;
    logic [CNT_W-1:0]   abs_err;
    logic               in_tol;

    // Lock FSM
    state_t             state_q;
    state_t             state_d;
    logic [GW-1:0]      good_q;
    logic [GW-1:0]      good_d;
    logic [BW-1:0]      bad_q;
    logic [BW-1:0]      bad_d;
    logic [LT_W-1:0]    lt_q;
    logic [LT_W-1:0]    lt_d;
    logic               lp_q;
    logic               lp_d;
    logic               up_q;
    logic               up_d;
    logic               loss_q;
    logic               loss_d;

    ref_edge_sync u_sync (
        .clk_i  (clockp),
        .rst_ni (resetb),
        .d_i    (osc),
        .edge_o (ref_edge)
    );

    assign active   = (state_q != ST_IDLE);
    assign div_chg  = active && (div != div_q);
    assign trim_smp = edge_dly_q[1];

    assign target = CNT_W'(div_q) * CNT_W'(WIN_REFS);
    assign tol    = target >> TOL_SHIFT;

    // Keep a registered div and delay ref_edge for trim sampling.
    always_ff @(posedge clockp or negedge resetb) begin
        if (!resetb) begin
            div_q      <= '0;
            edge_dly_q <= '0;
            trim_q     <= '0;
            stab_q     <= '0;
        end else begin
            div_q      <= div;
            edge_dly_q <= {edge_dly_q[0], ref_edge};
            trim_q     <= trim_d;
            stab_q     <= stab_d;
        end
    end

    // Count consecutive reference edges with an unchanged trim word.
    always_comb begin
        trim_d = trim_q;
        stab_d = stab_q;
        if (trim_smp) begin
            trim_d = trim;
            if (trim != trim_q) begin
                stab_d = '0;
            end else if (stab_q != STAB_MAX) begin
                stab_d = stab_q + SW'(1);
            end
        end
        if (!active) begin
            stab_d = '0;
        end
    end

    assign trim_stable = (stab_q == STAB_MAX);

    // Window state registers; meas/ferr hold while idle.
    always_ff @(posedge clockp or negedge resetb) begin
        if (!resetb) begin
            synced_q <= 1'b0;
            cnt_q    <= '0;
            refc_q   <= '0;
            meas_q   <= '0;
            ferr_q   <= '0;
            eval_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            synced_q <= synced_d;
            cnt_q    <= cnt_d;
            refc_q   <= refc_d;
            meas_q   <= meas_d;
            ferr_q   <= ferr_d;
            eval_q   <= eval_d;
            sat_q    <= sat_d;
        end
    end

    // Align to a reference edge, then close a window every WIN_REFS
    // edges or when the counter saturates because the reference died.
    always_comb begin
        synced_d = synced_q;
        cnt_d    = cnt_q;
        refc_d   = refc_q;
        meas_d   = meas_q;
        ferr_d   = ferr_q;
        eval_d   = 1'b0;
        sat_d    = sat_q;
        if (!active || div_chg) begin
            synced_d = 1'b0;
            cnt_d    = '0;
            refc_d   = '0;
        end else if (!synced_q) begin
            if (ref_edge) begin
                synced_d = 1'b1;
                cnt_d    = CNT_W'(1);
                refc_d   = '0;
            end
        end else if (ref_edge && (refc_q == REF_LAST)) begin
            meas_d = cnt_q;
            ferr_d = {1'b0, cnt_q} - {1'b0, target};
            eval_d = 1'b1;
            sat_d  = 1'b0;
            cnt_d  = CNT_W'(1);
            refc_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            meas_d = cnt_q;
            ferr_d = {1'b0, cnt_q} - {1'b0, target};
            eval_d = 1'b1;
            sat_d  = 1'b1;
            cnt_d  = CNT_W'(1);
            refc_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (ref_edge) begin
                refc_d = refc_q + RW'(1);
            end
        end
    end

    // Tolerance test on the registered error; saturation is always bad.
    always_comb begin
        ferr_neg = '0 - ferr_q;
        abs_err  = ferr_q[CNT_W] ? ferr_neg[CNT_W-1:0]
                                 : ferr_q[CNT_W-1:0];
        in_tol   = !sat_q && (abs_err <= tol);
    end

    // Lock FSM state, counters, pulses and sticky loss flag.
    always_ff @(posedge clockp or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            good_q  <= '0;
            bad_q   <= '0;
            lt_q    <= '0;
            lp_q    <= 1'b0;
            up_q    <= 1'b0;
            loss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            lt_q    <= lt_d;
            lp_q    <= lp_d;
            up_q    <= up_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state: acquisition needs stable trim, lock tolerates dither.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        lt_d    = lt_q;
        lp_d    = 1'b0;
        up_d    = 1'b0;
        loss_d  = loss_q;
        if (clear) begin
            loss_d = 1'b0;
        end
        if (!enable) begin
            state_d = ST_IDLE;
            good_d  = '0;
            bad_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                    bad_d   = '0;
                    lt_d    = '0;
                end
                ST_ACQUIRE: begin
                    if (div_chg) begin
                        good_d = '0;
                        bad_d  = '0;
                        lt_d   = '0;
                    end else begin
                        if (ref_edge && (lt_q != LT_MAX)) begin
                            lt_d = lt_q + LT_W'(1);
                        end
                        if (eval_q) begin
                            if (in_tol && trim_stable) begin
                                if (good_q == GOOD_LAST) begin
                                    state_d = ST_LOCKED;
                                    lp_d    = 1'b1;
                                    good_d  = '0;
                                    bad_d   = '0;
                                end else begin
                                    good_d = good_q + GW'(1);
                                end
                            end else begin
                                good_d = '0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (div_chg) begin
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                        bad_d   = '0;
                        lt_d    = '0;
                    end else if (eval_q) begin
                        if (!in_tol) begin
                            if (bad_q == BAD_LAST) begin
                                state_d = ST_ACQUIRE;
                                up_d    = 1'b1;
                                loss_d  = 1'b1;
                                lt_d    = '0;
                                bad_d   = '0;
                                good_d  = '0;
                            end else begin
                                bad_d = bad_q + BW'(1);
                            end
                        end else begin
                            bad_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign locked       = (state_q == ST_LOCKED);
    assign state        = state_q;
    assign meas_count   = meas_q;
    assign freq_err     = $signed(ferr_q);
    assign lock_time    = lt_q;
    assign lock_pulse   = lp_q;
    assign unlock_pulse = up_q;
    assign loss_flag    = loss_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: scoreboard bench for pll_lock_monitor.
// Time unit is abstract: clockp period 40 units, osc period 5*count units.
module tb_pll_lock_monitor;

    localparam int TRIM_W   = 26;
    localparam int DIV_W    = 5;
    localparam int CNT_W    = 12;
    localparam int LT_W     = 16;
    localparam int CLK_HALF = 20;
    localparam int OSC_HIGH = 160;
    localparam int S_IDLE   = 0;
    localparam int S_ACQ    = 1;
    localparam int S_LCK    = 2;

    logic                  clockp = 1'b0;
    logic                  resetb;
    logic                  enable;
    logic                  osc;
    logic [DIV_W-1:0]      div;
    logic [TRIM_W-1:0]     trim;
    logic [TRIM_W-1:0]     trim_base;
    logic                  tog_bit = 1'b0;
    logic                  clear;
    logic                  locked;
    logic [1:0]            state;
    logic [CNT_W-1:0]      meas_count;
    logic signed [CNT_W:0] freq_err;
    logic [LT_W-1:0]       lock_time;
    logic                  lock_pulse;
    logic                  unlock_pulse;
    logic                  loss_flag;

    typedef struct {
        bit is_lock;
        int meas;
        int ferr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   osc_per  = 800;
    bit   osc_run  = 1'b1;
    bit   trim_tog = 1'b0;

    assign trim = trim_base ^ TRIM_W'(tog_bit);

    pll_lock_monitor dut (
        .clockp       (clockp),
        .resetb       (resetb),
        .enable       (enable),
        .osc          (osc),
        .div          (div),
        .trim         (trim),
        .clear        (clear),
        .locked       (locked),
        .state        (state),
        .meas_count   (meas_count),
        .freq_err     (freq_err),
        .lock_time    (lock_time),
        .lock_pulse   (lock_pulse),
        .unlock_pulse (unlock_pulse),
        .loss_flag    (loss_flag)
    );

    always #CLK_HALF clockp = ~clockp;

    // Reference oscillator; trim toggles every second rising edge.
    initial begin
        int tog_n;
        tog_n = 0;
        osc = 1'b0;
        #3;
        forever begin
            if (osc_run) begin
                osc = 1'b1;
                if (trim_tog) begin
                    tog_n++;
                    if (tog_n % 2 == 0) tog_bit = ~tog_bit;
                end
                #OSC_HIGH;
                osc = 1'b0;
                #(osc_per - OSC_HIGH);
            end else begin
                #(osc_per);
            end
        end
    end

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(string name, int act, int lo, int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d",
                     name, act, lo, hi);
        end
    endtask

    task automatic push_exp(bit is_lock, int meas, int tgt);
        exp_t e;
        e.is_lock = is_lock;
        e.meas    = meas;
        e.ferr    = meas - tgt;
        exp_q.push_back(e);
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clockp);
    endtask

    task automatic set_count(int cnt);
        osc_per = 5 * cnt;
    endtask

    task automatic drain(int budget, string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clockp);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: timeout, got %0d pending events, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_clear();
        @(negedge clockp);
        clear = 1'b1;
        @(negedge clockp);
        clear = 1'b0;
        @(negedge clockp);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_state"},  int'(state), S_IDLE);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_lockp"},  int'(lock_pulse), 0);
        check({tag, "_unlockp"}, int'(unlock_pulse), 0);
        check({tag, "_loss"},   int'(loss_flag), 0);
        check({tag, "_meas"},   int'(meas_count), 0);
        check({tag, "_ferr"},   int'(freq_err), 0);
        check({tag, "_ltime"},  int'(lock_time), 0);
    endtask

    // Monitor: every lock/unlock pulse must match the next expected event.
    always @(negedge clockp) begin : mon
        exp_t e;
        if (resetb && (lock_pulse || unlock_pulse)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got lock=%0b unlock=%0b, expected none",
                         lock_pulse, unlock_pulse);
            end else begin
                e = exp_q.pop_front();
                check("event_lock",   int'(lock_pulse), int'(e.is_lock));
                check("event_unlock", int'(unlock_pulse), int'(!e.is_lock));
                check("event_meas",   int'(meas_count), e.meas);
                check("event_ferr",   int'(freq_err), e.ferr);
                check("event_locked", int'(locked), int'(e.is_lock));
                if (!e.is_lock) check("event_loss", int'(loss_flag), 1);
            end
        end
    end

    initial begin
        int prev_div;
        resetb    = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        div       = DIV_W'(20);
        trim_base = TRIM_W'($urandom);
        set_count(160);
        cycles(5);
        check_all_zero("reset");
        resetb = 1'b1;
        cycles(3);

        // Nominal lock at div 20, count 160.
        push_exp(1'b1, 160, 160);
        enable = 1'b1;
        drain(3000, "nominal_lock");
        check_range("nominal_lock_time", int'(lock_time), 23, 25);
        check("nominal_state", int'(state), S_LCK);

        // Count 163 is outside tolerance 2: lock drops and never returns.
        push_exp(1'b0, 163, 160);
        set_count(163);
        drain(3000, "tol163_unlock");
        cycles(7 * 163 + 50);
        check("tol163_state", int'(state), S_ACQ);
        check("tol163_loss", int'(loss_flag), 1);
        pulse_clear();
        check("clear_loss_a", int'(loss_flag), 0);

        // Count 162 sits on the tolerance edge and locks.
        push_exp(1'b1, 162, 160);
        set_count(162);
        drain(4000, "tol162_lock");

        // Lock loss at count 170.
        push_exp(1'b0, 170, 160);
        set_count(170);
        drain(3000, "loss170_unlock");
        check("loss170_flag", int'(loss_flag), 1);
        pulse_clear();
        check("clear_loss_b", int'(loss_flag), 0);

        // Correct frequency but toggling trim: no lock until it settles.
        trim_tog = 1'b1;
        set_count(160);
        cycles(8 * 160 + 50);
        check("trimtog_state", int'(state), S_ACQ);
        check("trimtog_locked", int'(locked), 0);
        trim_tog = 1'b0;
        push_exp(1'b1, 160, 160);
        drain(4000, "trimtog_lock");

        // div change while locked: silent reacquire at 176.
        push_exp(1'b1, 176, 176);
        @(negedge clockp);
        div = DIV_W'(22);
        set_count(176);
        cycles(5);
        check("divchg_state", int'(state), S_ACQ);
        check("divchg_loss", int'(loss_flag), 0);
        drain(4000, "divchg_lock");

        // Random div and frequency offsets around the tolerance band.
        prev_div = 22;
        for (int it = 0; it < 5; it++) begin
            int d;
            int tgt;
            int tl;
            int off;
            bit inl;
            d = 24 + int'($urandom % 8);
            while (d == prev_div) d = 24 + int'($urandom % 8);
            prev_div = d;
            tgt = d * 8;
            tl  = tgt >> 6;
            off = int'($urandom_range(0, 2 * tl + 4)) - (tl + 2);
            inl = (off <= tl) && (off >= -tl);
            if (inl) push_exp(1'b1, tgt + off, tgt);
            @(negedge clockp);
            div = DIV_W'(d);
            set_count(tgt + off);
            if (inl) drain(5000, "rand_lock");
            else cycles(7 * (tgt + off) + 50);
            check("rand_state", int'(state), inl ? S_LCK : S_ACQ);
        end

        // Relock at 160, then kill the reference.
        push_exp(1'b1, 160, 160);
        @(negedge clockp);
        div = DIV_W'(20);
        set_count(160);
        drain(4000, "final_lock");
        push_exp(1'b0, (1 << CNT_W) - 1, 160);
        osc_run = 1'b0;
        drain(12000, "refloss_unlock");
        check("refloss_state", int'(state), S_ACQ);
        check("refloss_loss", int'(loss_flag), 1);

        // Asynchronous reset mid-window clears everything at once.
        cycles(37);
        #7;
        resetb = 1'b0;
        #1;
        check_all_zero("midreset");
        cycles(3);
        resetb = 1'b1;
        cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Synthesizable lock detector and frequency monitor for `digital_pll`. It runs on the PLL output clock and counts output cycles over a window of reference (`osc`) periods. It compares the count against `div`, qualifies the result with controller-trim stability, and reports lock, loss of lock, measured error and lock time in hardware. This replaces bench-only lock checking with a parametrised on-chip block that has hysteresis and reference-loss detection.

## Interface
- `TRIM_W`, 26, width of the trim bus being monitored
- `DIV_W`, 5, width of `div`
- `WIN_REFS`, 8, reference periods per measurement window (power of 2, ≥2)
- `CNT_W`, 12, window counter width; must hold `(2^DIV_W-1)*WIN_REFS`
- `TOL_SHIFT`, 6, tolerance = `target >> TOL_SHIFT`, ≈1.6 %
- `LOCK_WINS`, 3, consecutive good windows required to declare lock
- `UNLOCK_WINS`, 2, consecutive bad windows required to drop lock
- `TRIM_STABLE`, 5, reference periods of unchanged trim required during acquisition
- `LT_W`, 16, lock-time counter width, in reference periods
- `clockp`  in  1  monitor clock (PLL output); single clock domain
- `resetb`  in  1  asynchronous, active-low reset
- `enable`  in  1  monitor enable; level-sensitive
- `osc`  in  1  reference clock, asynchronous to `clockp`, treated as data
- `div`  in  DIV_W  PLL divide ratio; quasi-static
- `trim`  in  TRIM_W  controller trim word (changes on `osc` edges)
- `clear`  in  1  clears `loss_flag`
- `locked`  out  1  lock indication
- `state`  out  2  FSM state code
- `meas_count`  out  CNT_W  last completed window count
- `freq_err`  out  CNT_W+1  signed `meas_count - target`
- `lock_time`  out  LT_W  reference periods from acquisition start to lock
- `lock_pulse`  out  1  one-cycle pulse on lock
- `unlock_pulse`  out  1  one-cycle pulse on lock loss
- `loss_flag`  out  1  sticky; set by `unlock_pulse`, cleared by `clear`

## Operation
- **Reference edge detection.** `osc` passes through a 2-FF synchronizer plus an edge detector, giving `ref_edge` (one cycle per rising edge).
- **Trim sampling.** `trim` is sampled 2 cycles after `ref_edge`. This is safe for `div` ≥ 4.
- **Trim stability.** `trim_stable` is set when the sampled trim is unchanged for `TRIM_STABLE` consecutive reference edges.
- **Window counting.** The window counter increments every cycle. At every `WIN_REFS`-th `ref_edge` (window end):
  - `meas_count` ← counter; the counter restarts at 1.
  - `target = div*WIN_REFS`.
  - `in_tol = |meas_count - target| ≤ target>>TOL_SHIFT`.
- **Reference loss.** If the counter saturates at all-ones, the window is forced closed as out-of-tolerance and the counter restarts.
- **FSM states:** IDLE=0, ACQUIRE=1, LOCKED=2.
  - **IDLE:** all counters clear. On `enable`=1 → ACQUIRE; `lock_time` ← 0.
  - **ACQUIRE:**
    - At window end: if `in_tol && trim_stable`, `good`++; otherwise `good`←0.
    - When `good`=`LOCK_WINS` → LOCKED; `lock_pulse`; `lock_time` freezes.
    - `lock_time` increments on each `ref_edge` and saturates at all-ones.
  - **LOCKED:**
    - Trim stability is ignored (dither is allowed).
    - At window end: if `!in_tol`, `bad`++; otherwise `bad`←0.
    - When `bad`=`UNLOCK_WINS` → ACQUIRE; `unlock_pulse`; `loss_flag`←1; `lock_time`←0.
- **`div` change** (registered copy differs) in ACQUIRE or LOCKED:
  - Abort the current window and restart it.
  - Set `good`, `bad` and `lock_time` to 0; FSM → ACQUIRE.
  - No `unlock_pulse` and no `loss_flag`.
- **`enable`=0:** → IDLE on the next cycle from any state. `meas_count` and `loss_flag` hold.
- **Simultaneous `clear` and unlock:** the set wins.
- **`locked`** = (state==LOCKED).

## Timing
- Reset values:
  - state IDLE; `locked`, `lock_pulse`, `unlock_pulse`, `loss_flag` = 0.
  - `meas_count`, `freq_err`, `lock_time` = 0.
- `osc` rising edge to `ref_edge`: 3 `clockp` cycles.
- Window end to `meas_count`/`freq_err` valid: 1 cycle.
- `meas_count`/`freq_err` valid to state update and pulses: 1 cycle.
- Reset asserted mid-window: all state clears immediately; the first window after release is discarded (partial).

## Structure
- Package `pll_mon_pkg`: state enum (IDLE/ACQUIRE/LOCKED) and state width.
- Sub-module `ref_edge_sync`: 2-FF synchronizer and rising-edge detector. All other logic lives in the top module.

## Test plan
1. **Nominal lock.** `div`=20, `osc` 100 ns, `clockp` 5 ns, trim constant. Required: `meas_count`=160, `freq_err`=0, `locked` after 3 windows, `lock_time`=24±1.
2. **Tolerance edge.** `clockp` period chosen for a count of 162, then 163. Required: 162 locks; 163 never locks (tol=2).
3. **Trim toggling.** Trim toggles every 2 `osc` periods, frequency correct. Required: stays in ACQUIRE. Stop the toggling → locks 5 ref edges plus remaining windows later.
4. **Lock loss.** While LOCKED, shift `clockp` to give a count of 170. Required: `unlock_pulse` after 2 windows, `loss_flag`=1. Pulse `clear` → `loss_flag`=0.
5. **`div` change while locked.** `div` 20→22. Required: ACQUIRE, no `unlock_pulse`, relock with `meas_count`=176.
6. **Reference loss and reset.** `osc` stopped → counter saturation closes the window as bad and lock drops. `resetb` pulsed mid-window → all outputs 0 within 1 cycle.
